// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state encoding for the UART transmit arbiter
// Contents:
//   UART_DATA_W  byte width carried per grant
//   arb_state_e  arbiter states: ARB_IDLE, ARB_START, ARB_WAIT
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_START = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin winner search
// Ports:
//   req     in   NUM_REQ  request vector
//   ptr     in   ID_W     last served index; search starts at ptr+1
//   found   out  1        at least one request is set
//   winner  out  ID_W     first set index after ptr, modulo NUM_REQ
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    winner
);

    int cand;

    // Wrap is modulo NUM_REQ, so non-power-of-two requester counts never
    // visit an index that does not exist.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[cand[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin scheduler sharing one 8N1 UART transmitter
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           grant enable (in-flight frame always completes)
//   req_valid    per-requester byte pending
//   req_data     byte of requester i at [8*i+7:8*i]
//   req_ack      one-cycle capture pulse per requester
//   tx_start     frame start request to transmitter, held until tx_busy
//   tx_data      byte to transmit, held between frames
//   tx_busy      transmitter frame in progress
//   active       arbiter owns the transmitter
//   grant_id     current or last granted requester
//   frame_done   one-cycle pulse when tx_busy falls
//   done_id      requester of the last completed frame
//   timeout_err  one-cycle pulse when tx_busy never rose
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int BUSY_TO = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic                           tx_start,
    output logic [UART_DATA_W-1:0]         tx_data,
    input  logic                           tx_busy,
    output logic                           active,
    output logic [ID_W-1:0]                grant_id,
    output logic                           frame_done,
    output logic [ID_W-1:0]                done_id,
    output logic                           timeout_err
);

    localparam int                  TIMER_W    = $clog2(BUSY_TO);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(BUSY_TO - 1);
    localparam logic [ID_W-1:0]     PTR_RESET  = ID_W'(NUM_REQ - 1);

    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [NUM_REQ-1:0]     req_ack_q, req_ack_d;
    logic                   tx_start_q, tx_start_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic                   active_q, active_d;
    logic [ID_W-1:0]        grant_id_q, grant_id_d;
    logic                   frame_done_q, frame_done_d;
    logic [ID_W-1:0]        done_id_q, done_id_d;
    logic                   timeout_err_q, timeout_err_d;

    logic                   pick_found;
    logic [ID_W-1:0]        pick_id;
    logic [UART_DATA_W-1:0] req_bytes [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[i*UART_DATA_W +: UART_DATA_W];
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .found  (pick_found),
        .winner (pick_id)
    );

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        timer_d       = timer_q;
        tx_start_d    = tx_start_q;
        tx_data_d     = tx_data_q;
        active_d      = active_q;
        grant_id_d    = grant_id_q;
        done_id_d     = done_id_q;
        req_ack_d     = '0;
        frame_done_d  = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // A busy transmitter here belongs to someone else; wait it out.
                if (en && !tx_busy && pick_found) begin
                    tx_data_d          = req_bytes[pick_id];
                    grant_id_d         = pick_id;
                    req_ack_d[pick_id] = 1'b1;
                    tx_start_d         = 1'b1;
                    active_d           = 1'b1;
                    timer_d            = '0;
                    state_d            = ARB_START;
                end
            end
            ARB_START: begin
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = ARB_WAIT;
                end else if (timer_q == TIMER_LAST) begin
                    // Byte is dropped; the requester was already acked.
                    tx_start_d    = 1'b0;
                    active_d      = 1'b0;
                    timeout_err_d = 1'b1;
                    rr_ptr_d      = grant_id_q;
                    state_d       = ARB_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ARB_WAIT: begin
                if (!tx_busy) begin
                    frame_done_d = 1'b1;
                    done_id_d    = grant_id_q;
                    rr_ptr_d     = grant_id_q;
                    active_d     = 1'b0;
                    state_d      = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB_IDLE;
            rr_ptr_q      <= PTR_RESET;
            timer_q       <= '0;
            req_ack_q     <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            active_q      <= 1'b0;
            grant_id_q    <= '0;
            frame_done_q  <= 1'b0;
            done_id_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            timer_q       <= timer_d;
            req_ack_q     <= req_ack_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            active_q      <= active_d;
            grant_id_q    <= grant_id_d;
            frame_done_q  <= frame_done_d;
            done_id_q     <= done_id_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign req_ack     = req_ack_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign active      = active_q;
    assign grant_id    = grant_id_q;
    assign frame_done  = frame_done_q;
    assign done_id     = done_id_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a bit-level 8N1 transmitter model
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int BUSY_TO = 8;
    localparam int CPB     = 2;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b0;
    logic                 en        = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ*8-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]   req_ack;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 active;
    logic [ID_W-1:0]      grant_id;
    logic                 frame_done;
    logic [ID_W-1:0]      done_id;
    logic                 timeout_err;

    int busy_mode = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .BUSY_TO (BUSY_TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .active      (active),
        .grant_id    (grant_id),
        .frame_done  (frame_done),
        .done_id     (done_id),
        .timeout_err (timeout_err)
    );

    logic       m_busy;
    logic       m_txd;
    logic [9:0] m_sh;
    int         m_cnt;

    assign tx_busy = (busy_mode == 0) ? m_busy : (busy_mode == 2);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_txd  <= 1'b1;
            m_sh   <= '0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (tx_start && busy_mode == 0) begin
                m_busy <= 1'b1;
                m_sh   <= {1'b1, tx_data, 1'b0};
                m_txd  <= 1'b0;
                m_cnt  <= 0;
            end
        end else if (m_cnt == 10*CPB-1) begin
            m_busy <= 1'b0;
            m_txd  <= 1'b1;
        end else begin
            m_cnt <= m_cnt + 1;
            if ((m_cnt + 1) % CPB == 0) begin
                m_sh  <= m_sh >> 1;
                m_txd <= m_sh[1];
            end
        end
    end

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [7:0]      data;
    } grant_t;

    grant_t          exp_grant_q[$];
    logic [ID_W-1:0] exp_done_q[$];
    logic [ID_W-1:0] exp_to_q[$];
    logic [7:0]      exp_ser_q[$];

    int checks   = 0;
    int failures = 0;
    int remaining [NUM_REQ];
    bit chk_b2b  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    logic            prev_fd, prev_active, prev_start, prev_busy;
    bit              rx_active;
    int              rx_k;
    logic [7:0]      rx_byte;
    grant_t          g;
    logic [ID_W-1:0] e_id;
    logic [7:0]      e_byte;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_fd     = 1'b0;
            prev_active = 1'b0;
            prev_start  = 1'b0;
            prev_busy   = 1'b0;
            rx_active   = 1'b0;
        end else begin
            if (chk_b2b && prev_fd && exp_grant_q.size() != 0) begin
                chk("b2b_tx_start", 32'(tx_start), 32'd1);
            end
            if (req_ack != '0) begin
                chk("ack_from_idle", 32'(prev_active), 32'd0);
                if (exp_grant_q.size() == 0) begin
                    chk("unexpected_ack", 32'(req_ack), 32'd0);
                end else begin
                    g = exp_grant_q.pop_front();
                    chk("ack_vec", 32'(req_ack), 32'd1 << g.id);
                    chk("grant_id", 32'(grant_id), 32'(g.id));
                    chk("tx_data", 32'(tx_data), 32'(g.data));
                    chk("tx_start_at_grant", 32'(tx_start), 32'd1);
                    chk("active_at_grant", 32'(active), 32'd1);
                end
            end
            if (prev_start && prev_busy) begin
                chk("tx_start_drop", 32'(tx_start), 32'd0);
            end
            if (frame_done) begin
                if (exp_done_q.size() == 0) begin
                    chk("unexpected_done", 32'(frame_done), 32'd0);
                end else begin
                    e_id = exp_done_q.pop_front();
                    chk("done_id", 32'(done_id), 32'(e_id));
                    chk("active_at_done", 32'(active), 32'd0);
                end
            end
            if (timeout_err) begin
                if (exp_to_q.size() == 0) begin
                    chk("unexpected_timeout", 32'(timeout_err), 32'd0);
                end else begin
                    e_id = exp_to_q.pop_front();
                    chk("timeout_grant_id", 32'(grant_id), 32'(e_id));
                    chk("timeout_active", 32'(active), 32'd0);
                    chk("timeout_tx_start", 32'(tx_start), 32'd0);
                    chk("timeout_no_done", 32'(frame_done), 32'd0);
                end
            end
            if (!rx_active) begin
                if (m_txd == 1'b0) begin
                    rx_active = 1'b1;
                    rx_k      = 0;
                    rx_byte   = '0;
                end
            end else begin
                rx_k++;
                if (rx_k >= CPB && rx_k < 9*CPB && (rx_k % CPB) == CPB-1) begin
                    rx_byte = {m_txd, rx_byte[7:1]};
                end
                if (rx_k == 10*CPB-1) begin
                    rx_active = 1'b0;
                    chk("serial_stop_bit", 32'(m_txd), 32'd1);
                    if (exp_ser_q.size() == 0) begin
                        chk("unexpected_serial", 32'(rx_byte), 32'hFFFF_FFFF);
                    end else begin
                        e_byte = exp_ser_q.pop_front();
                        chk("serial_byte", 32'(rx_byte), 32'(e_byte));
                    end
                end
            end
            prev_fd     = frame_done;
            prev_active = active;
            prev_start  = tx_start;
            prev_busy   = tx_busy;
        end
    end

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ack[i]) begin
                if (remaining[i] <= 1) begin
                    remaining[i] = 0;
                    req_valid[i] = 1'b0;
                end else begin
                    remaining[i]--;
                end
            end
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input int cnt);
        req_data[i*8 +: 8] = d;
        remaining[i]       = cnt;
        req_valid[i]       = 1'b1;
    endtask

    task automatic expect_frame(input logic [ID_W-1:0] id, input logic [7:0] d);
        grant_t e;
        e.id   = id;
        e.data = d;
        exp_grant_q.push_back(e);
        exp_done_q.push_back(id);
        exp_ser_q.push_back(d);
    endtask

    function automatic int pending();
        return exp_grant_q.size() + exp_done_q.size() + exp_to_q.size()
             + exp_ser_q.size() + int'(active) + int'(tx_busy);
    endfunction

    task automatic wait_quiet(input string name, input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (pending() != 0 && n < budget);
        chk({name, "_drained"}, 32'(pending()), 32'd0);
    endtask

    initial begin
        int cnt;
        int n;
        for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;

        repeat (3) @(negedge clk);
        chk("rst_req_ack", 32'(req_ack), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        en    = 1'b1;

        // All four requesters: from reset pointer 3 the order is 0,1,2,3,0.
        chk_b2b = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) expect_frame(ID_W'(i), 8'h10 + 8'(i));
        expect_frame(2'd0, 8'h10);
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'h10 + 8'(i), (i == 0) ? 2 : 1);
        wait_quiet("rr_all", 400);
        chk_b2b = 1'b0;

        // Single byte A5 from requester 0; pointer becomes 0.
        expect_frame(2'd0, 8'hA5);
        set_req(0, 8'hA5, 1);
        wait_quiet("single", 100);

        // en low blocks grants; after enabling, requester 1 wins; en drop mid-frame.
        en  = 1'b0;
        cnt = 0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'h20 + 8'(i), 1);
        for (int i = 0; i < 12; i++) begin
            step();
            if (tx_start || req_ack != '0) cnt++;
        end
        chk("en0_no_grant", 32'(cnt), 32'd0);
        expect_frame(2'd1, 8'h21);
        en = 1'b1;
        n  = 0;
        do begin
            step();
            n++;
        end while (!active && n < 10);
        chk("en1_active", 32'(active), 32'd1);
        en = 1'b0;
        wait_quiet("en_drop", 100);
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;
        en = 1'b1;

        // No tx_busy: tx_start high BUSY_TO cycles, then timeout; pointer becomes 2.
        busy_mode = 1;
        exp_grant_q.push_back('{id: 2'd2, data: 8'h42});
        exp_to_q.push_back(2'd2);
        set_req(2, 8'h42, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tx_start) cnt++;
        end
        chk("timeout_tx_start_cycles", 32'(cnt), 32'(BUSY_TO));
        wait_quiet("timeout", 20);
        busy_mode = 0;
        expect_frame(2'd3, 8'h33);
        expect_frame(2'd0, 8'h30);
        expect_frame(2'd2, 8'h32);
        set_req(0, 8'h30, 1);
        set_req(2, 8'h32, 1);
        set_req(3, 8'h33, 1);
        wait_quiet("after_timeout", 300);

        // Foreign busy in IDLE: no grant until it falls, then grant next edge.
        busy_mode = 2;
        set_req(1, 8'h5A, 1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tx_start || req_ack != '0) cnt++;
        end
        chk("busy_idle_no_grant", 32'(cnt), 32'd0);
        expect_frame(2'd1, 8'h5A);
        busy_mode = 0;
        step();
        chk("busy_fall_grant", 32'(req_ack), 32'b0010);
        wait_quiet("busy_idle", 100);

        // Reset in WAIT_DONE clears outputs at once and restores pointer to 3.
        exp_grant_q.push_back('{id: 2'd3, data: 8'h77});
        set_req(3, 8'h77, 1);
        n = 0;
        do begin
            step();
            n++;
        end while (!(active && !tx_start && tx_busy) && n < 20);
        chk("reached_wait_done", 32'(active && !tx_start && tx_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
        chk("mid_rst_active", 32'(active), 32'd0);
        chk("mid_rst_req_ack", 32'(req_ack), 32'd0);
        chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
        set_req(0, 8'h66, 1);
        set_req(3, 8'h78, 1);
        expect_frame(2'd0, 8'h66);
        expect_frame(2'd3, 8'h78);
        step();
        step();
        rst_n = 1'b1;
        wait_quiet("post_reset", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
